pir_sample_averager: RTL and testbench

// Front-end conditioning stage for the PIR alarm controller. Samples three raw 7-bit PIR levels

---
 rtl/pir_sample_averager.sv | 181 ++++++++++++++++++
 tb/tb_pir_sample_averager.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pir_sample_averager.sv
// PIR front-end conditioning: samples three raw 7-bit PIR levels every SAMPLE_PERIOD cycles,
// averages 2**LOG2_SAMPLES samples per channel into a window average, and debounces a per-channel
// motion flag over HOLD_WINDOWS consecutive windows whose average reaches THRESHOLD.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous reset, active low
//   enable         1 = run sampling windows, 0 = stop and discard the partial window
//   pir_sensor_1..3  raw PIR levels (unsigned, 7 bits)
//   average_1..3   last published window average, zero-extended to 8 bits
//   avg_valid      one-cycle pulse when averages/flags have just been updated
//   motion_flags   bit i-1 = channel i debounced motion
//   motion_any     OR of motion_flags, registered alongside them
//   window_cnt     windows published since reset, wraps at 255
module pir_sample_averager #(
  parameter int unsigned SAMPLE_PERIOD = 4,
  parameter int unsigned LOG2_SAMPLES  = 2,
  parameter int unsigned THRESHOLD     = 50,
  parameter int unsigned HOLD_WINDOWS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] pir_sensor_1,
  input  logic [6:0] pir_sensor_2,
  input  logic [6:0] pir_sensor_3,
  output logic [7:0] average_1,
  output logic [7:0] average_2,
  output logic [7:0] average_3,
  output logic       avg_valid,
  output logic [2:0] motion_flags,
  output logic       motion_any,
  output logic [7:0] window_cnt
);

  localparam int unsigned NumSamples = 2 ** LOG2_SAMPLES;
  localparam int unsigned AccW       = 7 + LOG2_SAMPLES;
  localparam int unsigned PeriodW    = $clog2(SAMPLE_PERIOD);
  localparam int unsigned SampleW    = LOG2_SAMPLES + 1;

  localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(SAMPLE_PERIOD - 1);
  localparam logic [SampleW-1:0] SampleLast = SampleW'(NumSamples - 1);
  localparam logic [7:0]         Thresh     = 8'(THRESHOLD);
  localparam logic [3:0]         HoldMax    = 4'(HOLD_WINDOWS);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPublish
  } state_e;

  state_e              state_q, state_d;
  logic [PeriodW-1:0]  period_cnt_q, period_cnt_d;
  logic [SampleW-1:0]  sample_cnt_q, sample_cnt_d;
  logic [AccW-1:0]     acc_q [3];
  logic [AccW-1:0]     acc_d [3];
  logic [3:0]          hold_q [3];
  logic [3:0]          hold_d [3];
  logic [7:0]          avg_q [3];
  logic [7:0]          avg_d [3];
  logic                avg_valid_q, avg_valid_d;
  logic [2:0]          flags_q, flags_d;
  logic                any_q, any_d;
  logic [7:0]          wcnt_q, wcnt_d;

  logic [6:0]          pir [3];
  logic [6:0]          new_avg [3];

  assign pir[0] = pir_sensor_1;
  assign pir[1] = pir_sensor_2;
  assign pir[2] = pir_sensor_3;

  // Truncating divide by the window size; the top bit of the 8-bit average is always 0.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      new_avg[i] = 7'(acc_q[i] >> LOG2_SAMPLES);
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    sample_cnt_d = sample_cnt_q;
    acc_d        = acc_q;
    hold_d       = hold_q;
    avg_d        = avg_q;
    flags_d      = flags_q;
    wcnt_d       = wcnt_q;
    avg_valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        period_cnt_d = '0;
        sample_cnt_d = '0;
        for (int i = 0; i < 3; i++) acc_d[i] = '0;
        flags_d = '0;
        if (enable) state_d = StWait;
      end

      StWait: begin
        if (!enable) begin
          // Partial window is dropped; nothing is published.
          state_d      = StIdle;
          period_cnt_d = '0;
          sample_cnt_d = '0;
          for (int i = 0; i < 3; i++) acc_d[i] = '0;
        end else if (period_cnt_q == PeriodLast) begin
          period_cnt_d = '0;
          sample_cnt_d = sample_cnt_q + 1'b1;
          for (int i = 0; i < 3; i++) acc_d[i] = acc_q[i] + AccW'(pir[i]);
          if (sample_cnt_q == SampleLast) state_d = StPublish;
        end else begin
          period_cnt_d = period_cnt_q + 1'b1;
        end
      end

      StPublish: begin
        for (int i = 0; i < 3; i++) begin
          avg_d[i] = {1'b0, new_avg[i]};
          if ({1'b0, new_avg[i]} >= Thresh) begin
            // Flag uses the pre-update count: this window plus the prior streak.
            flags_d[i] = ({1'b0, hold_q[i]} + 5'd1) >= {1'b0, HoldMax};
            hold_d[i]  = (hold_q[i] >= HoldMax) ? HoldMax : hold_q[i] + 4'd1;
          end else begin
            flags_d[i] = 1'b0;
            hold_d[i]  = 4'd0;
          end
          acc_d[i] = '0;
        end
        avg_valid_d  = 1'b1;
        wcnt_d       = wcnt_q + 8'd1;
        sample_cnt_d = '0;
        period_cnt_d = '0;
        state_d      = enable ? StWait : StIdle;
      end

      default: state_d = StIdle;
    endcase

    any_d = |flags_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      sample_cnt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= '0;
        hold_q[i] <= '0;
        avg_q[i]  <= '0;
      end
      avg_valid_q  <= 1'b0;
      flags_q      <= '0;
      any_q        <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= acc_d[i];
        hold_q[i] <= hold_d[i];
        avg_q[i]  <= avg_d[i];
      end
      avg_valid_q  <= avg_valid_d;
      flags_q      <= flags_d;
      any_q        <= any_d;
      wcnt_q       <= wcnt_d;
    end
  end

  assign average_1    = avg_q[0];
  assign average_2    = avg_q[1];
  assign average_3    = avg_q[2];
  assign avg_valid    = avg_valid_q;
  assign motion_flags = flags_q;
  assign motion_any   = any_q;
  assign window_cnt   = wcnt_q;

endmodule

// File: tb/tb_pir_sample_averager.sv
// Self-checking bench for pir_sample_averager: a behavioural model predicts each published window
// and pushes it into a queue; a monitor pops and compares on every avg_valid pulse.
module tb_pir_sample_averager;

  localparam int SP = 4;
  localparam int L2 = 2;
  localparam int NS = 1 << L2;
  localparam int TH = 50;
  localparam int HW = 2;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [6:0] pir_sensor_1, pir_sensor_2, pir_sensor_3;
  logic [7:0] average_1, average_2, average_3;
  logic       avg_valid;
  logic [2:0] motion_flags;
  logic       motion_any;
  logic [7:0] window_cnt;

  pir_sample_averager #(
    .SAMPLE_PERIOD(SP),
    .LOG2_SAMPLES (L2),
    .THRESHOLD    (TH),
    .HOLD_WINDOWS (HW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pir_sensor_1 (pir_sensor_1),
    .pir_sensor_2 (pir_sensor_2),
    .pir_sensor_3 (pir_sensor_3),
    .average_1    (average_1),
    .average_2    (average_2),
    .average_3    (average_3),
    .avg_valid    (avg_valid),
    .motion_flags (motion_flags),
    .motion_any   (motion_any),
    .window_cnt   (window_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    logic [2:0] flags;
    logic [7:0] wcnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [20:0] samp_q[$];
  int          total = 0;
  int          bad = 0;

  // Reference model state
  bit running;
  int pos;
  int m_wcnt;
  int m_hold[3];
  int m_avg[3];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the behaviour rules for the rising edge that is about to happen.
  task automatic model_edge();
    int   sum[3];
    exp_t e;
    if (!rst_n) begin
      running = 0;
      pos     = 0;
      samp_q.delete();
      m_wcnt  = 0;
      for (int i = 0; i < 3; i++) begin
        m_hold[i] = 0;
        m_avg[i]  = 0;
      end
    end else if (!running) begin
      if (enable) begin
        running = 1;
        pos     = 0;
        samp_q.delete();
      end
    end else if (pos == SP * NS) begin
      sum = '{0, 0, 0};
      foreach (samp_q[j]) begin
        sum[0] += int'(samp_q[j][20:14]);
        sum[1] += int'(samp_q[j][13:7]);
        sum[2] += int'(samp_q[j][6:0]);
      end
      e.flags = 3'b000;
      for (int i = 0; i < 3; i++) begin
        m_avg[i] = sum[i] / NS;
        if (m_avg[i] >= TH) begin
          e.flags[i] = (m_hold[i] + 1 >= HW);
          m_hold[i]  = (m_hold[i] + 1 > HW) ? HW : m_hold[i] + 1;
        end else begin
          m_hold[i] = 0;
        end
      end
      m_wcnt = (m_wcnt + 1) % 256;
      e.a1   = 8'(m_avg[0]);
      e.a2   = 8'(m_avg[1]);
      e.a3   = 8'(m_avg[2]);
      e.wcnt = 8'(m_wcnt);
      exp_q.push_back(e);
      samp_q.delete();
      pos     = 0;
      running = enable;
    end else if (!enable) begin
      running = 0;
      samp_q.delete();
    end else begin
      pos++;
      if (pos % SP == 0) samp_q.push_back({pir_sensor_1, pir_sensor_2, pir_sensor_3});
    end
  endtask

  // One clock: model the edge, let it happen, return just after the falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Leaves the DUT one edge into a fresh window.
  task automatic start();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic window4(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                         input logic [6:0] a3, input logic [6:0] b, input logic [6:0] c);
    logic [6:0] s[4];
    s[0] = a0;
    s[1] = a1;
    s[2] = a2;
    s[3] = a3;
    pir_sensor_2 = b;
    pir_sensor_3 = c;
    for (int k = 0; k < 4; k++) begin
      pir_sensor_1 = s[k];
      repeat (SP) step();
    end
    step();
  endtask

  task automatic window_const(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    window4(a, a, a, a, b, c);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_average_1"}, average_1, 0);
    chk({tag, "_average_2"}, average_2, 0);
    chk({tag, "_average_3"}, average_3, 0);
    chk({tag, "_avg_valid"}, avg_valid, 0);
    chk({tag, "_motion_flags"}, motion_flags, 0);
    chk({tag, "_motion_any"}, motion_any, 0);
    chk({tag, "_window_cnt"}, window_cnt, 0);
  endtask

  // Monitor: every avg_valid must match the next predicted window, and every prediction
  // must show up on the falling edge right after its publish edge.
  always @(negedge clk) begin
    exp_t e;
    if (avg_valid || exp_q.size() != 0) begin
      if (!avg_valid) begin
        total++;
        bad++;
        $display("FAIL missing_avg_valid: got 0 expected 1 at %0t", $time);
        void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_avg_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_average_1", average_1, e.a1);
        chk("sb_average_2", average_2, e.a2);
        chk("sb_average_3", average_3, e.a3);
        chk("sb_motion_flags", motion_flags, e.flags);
        chk("sb_motion_any", motion_any, int'(|e.flags));
        chk("sb_window_cnt", window_cnt, e.wcnt);
      end
    end
  end

  initial begin
    int first;
    int lo;
    rst_n        = 1'b0;
    enable       = 1'b1;
    pir_sensor_1 = 7'd127;
    pir_sensor_2 = 7'd127;
    pir_sensor_3 = 7'd127;

    // Reset held with enable and full-scale inputs.
    repeat (3) step();
    chk_all_zero("in_reset");

    // Release: the releasing edge starts the window; counting it, publish is the 18th edge.
    rst_n = 1'b1;
    step();
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (avg_valid && first < 0) first = k;
    end
    chk("first_valid_edges_after_enable", first, 17);

    // Constant inputs, debounce across two windows.
    do_reset();
    start();
    window_const(7'd60, 7'd20, 7'd50);
    chk("w1_motion_flags", motion_flags, 3'b000);
    window_const(7'd60, 7'd20, 7'd50);
    chk("w2_motion_flags", motion_flags, 3'b101);
    chk("w2_motion_any", motion_any, 1);
    chk("w2_window_cnt", window_cnt, 2);

    // Truncation and full scale.
    window4(7'd10, 7'd20, 7'd30, 7'd41, 7'd0, 7'd0);
    chk("trunc_average_1", average_1, 25);
    window_const(7'd127, 7'd127, 7'd127);
    chk("full_average_1", average_1, 127);
    chk("full_average_3", average_3, 127);

    // Flag set on window 2, held on 3, cleared on first sub-threshold window.
    do_reset();
    start();
    window_const(7'd70, 7'd0, 7'd0);
    chk("hold_w1_flag", motion_flags[0], 0);
    window_const(7'd70, 7'd0, 7'd0);
    chk("hold_w2_flag", motion_flags[0], 1);
    window_const(7'd70, 7'd0, 7'd0);
    chk("hold_w3_flag", motion_flags[0], 1);
    window_const(7'd49, 7'd0, 7'd0);
    chk("hold_w4_flag", motion_flags[0], 0);
    chk("hold_w4_any", motion_any, 0);

    // Enable drop mid-window: partial samples discarded, averages hold, flags clear in idle.
    window_const(7'd70, 7'd70, 7'd70);
    window_const(7'd70, 7'd70, 7'd70);
    chk("pre_drop_flags", motion_flags, 3'b111);
    pir_sensor_1 = 7'd120;
    pir_sensor_2 = 7'd120;
    pir_sensor_3 = 7'd120;
    repeat (2 * SP) step();
    enable = 1'b0;
    step();
    step();
    chk("drop_average_1_holds", average_1, 70);
    chk("drop_flags_cleared", motion_flags, 0);
    chk("drop_any_cleared", motion_any, 0);
    enable = 1'b1;
    step();
    window_const(7'd10, 7'd12, 7'd14);
    chk("reenable_average_1", average_1, 10);

    // Reset landing one cycle before the publish cycle.
    pir_sensor_1 = 7'd90;
    repeat (SP * NS - 1) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all_zero("late_reset");
    repeat (5) step();

    // Randomized traffic with occasional enable drops and resets.
    lo = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) lo = $urandom_range(0, 67);
      pir_sensor_1 = 7'($urandom_range(lo, lo + 60));
      pir_sensor_2 = 7'($urandom_range(lo, lo + 60));
      pir_sensor_3 = 7'($urandom_range(0, 127));
      enable       = ($urandom_range(0, 59) != 0);
      rst_n        = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n  = 1'b1;
    enable = 1'b0;
    repeat (4) step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
